wb_ram_slave: RTL and testbench
===============================

# wb_ram_slave

Wishbone classic (B3) slave wrapping a word-organised on-chip RAM, with programmable wait states, byte-lane writes, address-window decode and retry/error responses. It plugs into one slave port of the shared-bus interconnect. It receives the interconnect's muxed adr/dat/sel/we/cyc and its per-slave gated stb. It returns dat_o/ack_o/err_o/rty_o, which the interconnect ORs and routes to the granted master.

## Interface
- DATA_WIDTH, 32: data bus width in bits (8, 16, 32 or 64).
- ADDR_WIDTH, 32: byte address width.
- SELECT_WIDTH, DATA_WIDTH/8: byte-select width.
- DEPTH, 256: RAM depth in words; power of two, ≥ 2.
- BASE_ADDR, 0: byte address of word 0; aligned to DEPTH*SELECT_WIDTH.
- WAIT_STATES, 1: extra cycles inserted before the response; range 0..15.
- clk, in, 1: clock.
- rst, in, 1: reset; synchronous, active-high.
- adr_i, in, ADDR_WIDTH: byte address.
- dat_i, in, DATA_WIDTH: write data.
- dat_o, out, DATA_WIDTH: read data.
- we_i, in, 1: 1 = write, 0 = read.
- sel_i, in, SELECT_WIDTH: byte-lane enables.
- stb_i, in, 1: strobe (already gated by the interconnect's address compare).
- cyc_i, in, 1: bus cycle.
- hold_i, in, 1: slave busy; a request sampled while high is answered with retry.
- ack_o, out, 1: normal termination.
- err_o, out, 1: error termination.
- rty_o, out, 1: retry termination.

## Operation
- Request = cyc_i & stb_i, sampled only in state IDLE.
- Decode at the request edge, in priority order:
  - ERR_RESP: adr_i outside [BASE_ADDR, BASE_ADDR + DEPTH*SELECT_WIDTH), or adr_i[log2(SELECT_WIDTH)-1:0] ≠ 0.
  - RTY_RESP: hold_i = 1.
  - Otherwise a valid access.
- Word index = (adr_i − BASE_ADDR) >> log2(SELECT_WIDTH), truncated to log2(DEPTH) bits.
- adr_i, dat_i, we_i, sel_i and the index are latched at the request edge. Bus changes after that edge are ignored.
- States:
  - IDLE: on a request, go to ERR_RESP, RTY_RESP, WAIT (valid and WAIT_STATES > 0, counter loaded with WAIT_STATES−1), or ACK (valid and WAIT_STATES = 0, access performed at that edge).
  - WAIT: counter decrements each cycle. At counter = 0, perform the access and go to ACK. If cyc_i or stb_i is low in any WAIT cycle, go to IDLE: no access, no response.
  - ACK / ERR_RESP / RTY_RESP: the matching output is high for exactly this one cycle, then IDLE.
- Write access: for each lane b with sel[b] = 1, mem[idx][8b+7:8b] ← dat[8b+7:8b]. Lanes with sel = 0 are untouched. sel = 0 writes nothing but is still acked.
- Read access: dat_o ← mem[idx] at the access edge. dat_o holds that value until the next read access; writes, err and rty leave it unchanged.
- At most one of ack_o/err_o/rty_o is high in any cycle.
- Reset:
  - State → IDLE; counter → 0.
  - ack_o, err_o, rty_o, dat_o → 0.
  - RAM contents are not reset.
  - Reset during WAIT cancels the access; no write occurs.

## Timing
- Outputs are registered; there is no combinational path from inputs to outputs.
- Request sampled at edge E0. The access executes at edge E0+W (W = WAIT_STATES). The response is high from E0+W to E0+W+1.
- Valid access latency, stb_i rise to ack_o: W+1 cycles.
- err/rty latency: 1 cycle, independent of W.
- Back-to-back transfers: if stb_i is still high in the cycle after the response, IDLE samples it as a new request. Minimum period per transfer is W+2 cycles.
- The master must hold stb_i until the response. Dropping stb_i in the response cycle does not suppress the registered response.
- hold_i is sampled only at the request edge. Changes during WAIT have no effect.

## Test plan
- Reset: assert rst 2 cycles with stb_i = 1 → ack_o = err_o = rty_o = 0 and dat_o = 0 during and after reset; the first request after reset is served normally.
- W = 2: write 0xDEADBEEF to BASE+4, sel = 4'b1111 → ack_o high exactly in cycle 3 after stb_i rises. Read of BASE+4 → ack_o in cycle 3 with dat_o = 0xDEADBEEF.
- Byte lanes: write 0x0000AA00 to BASE+4 with sel = 4'b0010 → subsequent read returns 0xDEADAAEF. A write with sel = 0 is acked and the read is unchanged.
- Decode errors: access BASE + DEPTH*4 and BASE+2 → err_o for 1 cycle, 1 cycle after request, no ack_o, RAM unchanged, dat_o unchanged.
- Retry: hold_i = 1 at a write request → rty_o for 1 cycle, no write. Repeat with hold_i = 0 → ack_o and the write commits.
- Abort: W = 3, drop stb_i in the 2nd WAIT cycle → no response, no write. The next request completes with ack_o after 4 cycles.

Source files
------------

// File: rtl/wb_ram_slave.sv
`default_nettype none
// ============================================================================
// Module   : wb_ram_slave
// Purpose  : Wishbone classic (B3) slave around a word-organised RAM.
//            Programmable wait states, byte-lane writes, address-window
//            decode, error response for bad addresses, retry while held.
// Revision : 1.0 - initial release
// ============================================================================
module wb_ram_slave #(
   parameter int                    DATA_WIDTH   = 32,
   parameter int                    ADDR_WIDTH   = 32,
   parameter int                    SELECT_WIDTH = DATA_WIDTH / 8,
   parameter int                    DEPTH        = 256,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
   parameter int                    WAIT_STATES  = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ADDR_WIDTH-1:0]   adr_i,
   input  logic [DATA_WIDTH-1:0]   dat_i,
   output logic [DATA_WIDTH-1:0]   dat_o,
   input  logic                    we_i,
   input  logic [SELECT_WIDTH-1:0] sel_i,
   input  logic                    stb_i,
   input  logic                    cyc_i,
   input  logic                    hold_i,
   output logic                    ack_o,
   output logic                    err_o,
   output logic                    rty_o
);

   // Byte-offset bits inside one word and word-index bits of the RAM.
   localparam int SEL_BITS = (SELECT_WIDTH > 1) ? $clog2(SELECT_WIDTH) : 0;
   localparam int IDX_BITS = $clog2(DEPTH);

   // Window size in bytes, one bit wider than the address so it never wraps.
   localparam logic [ADDR_WIDTH:0] WINDOW = (ADDR_WIDTH + 1)'(DEPTH * SELECT_WIDTH);

   // Wait counter start value; the counter runs WAIT_STATES-1 down to 0.
   localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   // Response states each own one bit so the bus outputs are flop outputs.
   localparam logic [3:0] S_IDLE = 4'b0000;
   localparam logic [3:0] S_ACK  = 4'b0001;
   localparam logic [3:0] S_ERR  = 4'b0010;
   localparam logic [3:0] S_RTY  = 4'b0100;
   localparam logic [3:0] S_WAIT = 4'b1000;

   logic [3:0]              state;
   logic [3:0]              state_next;
   logic [3:0]              cnt;
   logic                    access;

   logic                    req;
   logic [ADDR_WIDTH:0]     offset;
   logic                    in_window;
   logic                    aligned;
   logic [IDX_BITS-1:0]     req_idx;

   logic [IDX_BITS-1:0]     lat_idx;
   logic [DATA_WIDTH-1:0]   lat_dat;
   logic [SELECT_WIDTH-1:0] lat_sel;
   logic                    lat_we;

   logic [IDX_BITS-1:0]     acc_idx;
   logic [DATA_WIDTH-1:0]   acc_dat;
   logic [SELECT_WIDTH-1:0] acc_sel;
   logic                    acc_we;

   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   // ---------------------------------------------------------------------
   // Request decode
   // ---------------------------------------------------------------------
   assign req       = cyc_i & stb_i;
   assign offset    = {1'b0, adr_i} - {1'b0, BASE_ADDR};
   assign in_window = (adr_i >= BASE_ADDR) && (offset < WINDOW);
   assign req_idx   = IDX_BITS'(offset >> SEL_BITS);

   if (SEL_BITS > 0) begin : g_align_check
      assign aligned = (adr_i[SEL_BITS-1:0] == '0);
   end else begin : g_align_none
      assign aligned = 1'b1;
   end

   // With no wait states the access happens on the request edge itself, so
   // the live bus is used; otherwise the values captured at that edge.
   assign acc_idx = (state == S_IDLE) ? req_idx : lat_idx;
   assign acc_dat = (state == S_IDLE) ? dat_i   : lat_dat;
   assign acc_sel = (state == S_IDLE) ? sel_i   : lat_sel;
   assign acc_we  = (state == S_IDLE) ? we_i    : lat_we;

   // ---------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode; 'access' marks the edge where the RAM is touched.
   always_comb begin
      state_next = state;
      access     = 1'b0;
      case (state)
         S_IDLE: begin
            if (req) begin
               if (!(in_window && aligned)) begin
                  state_next = S_ERR;
               end else if (hold_i) begin
                  state_next = S_RTY;
               end else if (WAIT_STATES == 0) begin
                  state_next = S_ACK;
                  access     = 1'b1;
               end else begin
                  state_next = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (!(cyc_i && stb_i)) begin
               state_next = S_IDLE;
            end else if (cnt == 4'd0) begin
               state_next = S_ACK;
               access     = 1'b1;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Termination outputs are taken straight from the state flops.
   always_comb begin
      ack_o = state[0];
      err_o = state[1];
      rty_o = state[2];
   end

   // Wait-state counter: loaded at the request edge, counts down in WAIT.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= 4'd0;
      end else if (state == S_IDLE && req) begin
         cnt <= CNT_LOAD;
      end else if (state == S_WAIT && cnt != 4'd0) begin
         cnt <= cnt - 4'd1;
      end
   end

   // Capture the transfer at the request edge; later bus changes are ignored.
   always_ff @(posedge clk) begin
      if (!rst && state == S_IDLE && req) begin
         lat_idx <= req_idx;
         lat_dat <= dat_i;
         lat_sel <= sel_i;
         lat_we  <= we_i;
      end
   end

   // RAM write with per-lane enables; contents survive reset.
   always_ff @(posedge clk) begin
      if (!rst && access && acc_we) begin
         for (int b = 0; b < SELECT_WIDTH; b++) begin
            if (acc_sel[b]) begin
               mem[acc_idx][8*b +: 8] <= acc_dat[8*b +: 8];
            end
         end
      end
   end

   // Read data register: updated only by a read access, held otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         dat_o <= '0;
      end else if (access && !acc_we) begin
         dat_o <= mem[acc_idx];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_wb_ram_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_ram_slave
// Purpose  : Self-checking bench for wb_ram_slave. Three instances with 0, 2
//            and 3 wait states share one bus; each has its own strobe.
//            Expected behaviour comes from a word-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_ram_slave;

   localparam int          DW    = 32;
   localparam int          AW    = 32;
   localparam int          SW    = 4;
   localparam int          DEPTH = 16;
   localparam int          NDUT  = 3;
   localparam logic [31:0] BASE  = 32'h0000_1000;

   logic            clk = 1'b0;
   logic            rst;
   logic [AW-1:0]   adr;
   logic [DW-1:0]   dat;
   logic            we;
   logic [SW-1:0]   sel;
   logic            cyc;
   logic            hold;
   logic [NDUT-1:0] stb;
   logic [NDUT-1:0] ack;
   logic [NDUT-1:0] err;
   logic [NDUT-1:0] rty;
   logic [DW-1:0]   dout [NDUT];

   int tests = 0;
   int fails = 0;

   // Reference model: RAM contents and the read-data register per instance.
   logic [31:0] mm    [NDUT][DEPTH];
   logic [31:0] mdout [NDUT];

   always #5 clk = ~clk;

   // Instance d has wait states 0, 2, 3 for d = 0, 1, 2.
   function automatic int wait_of(input int d);
      return (d == 0) ? 0 : d + 1;
   endfunction

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      wb_ram_slave #(
         .DATA_WIDTH  (DW),
         .ADDR_WIDTH  (AW),
         .SELECT_WIDTH(SW),
         .DEPTH       (DEPTH),
         .BASE_ADDR   (BASE),
         .WAIT_STATES ((g == 0) ? 0 : g + 1)
      ) u_dut (
         .clk   (clk),
         .rst   (rst),
         .adr_i (adr),
         .dat_i (dat),
         .dat_o (dout[g]),
         .we_i  (we),
         .sel_i (sel),
         .stb_i (stb[g]),
         .cyc_i (cyc),
         .hold_i(hold),
         .ack_o (ack[g]),
         .err_o (err[g]),
         .rty_o (rty[g])
      );
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // 0 = ack, 1 = err, 2 = rty
   function automatic int kind_of(input logic [31:0] a, input logic h);
      if (a < BASE || a >= BASE + DEPTH * SW || a[1:0] != 2'b00) return 1;
      if (h) return 2;
      return 0;
   endfunction

   // One complete transfer on instance d; every cycle's response is checked.
   task automatic xfer(input int d, input logic [31:0] a, input logic w,
                       input logic [31:0] wd, input logic [3:0] s, input logic h,
                       output logic [31:0] rd);
      int          k;
      int          lat;
      int          idx;
      logic [2:0]  exp_resp;
      k   = kind_of(a, h);
      lat = (k == 0) ? wait_of(d) + 1 : 1;
      idx = int'((a - BASE) >> 2) % DEPTH;
      @(negedge clk);
      adr = a; dat = wd; we = w; sel = s; hold = h; cyc = 1'b1; stb[d] = 1'b1;
      if (k == 0) begin
         if (w) begin
            for (int b = 0; b < SW; b++)
               if (s[b]) mm[d][idx][8*b +: 8] = wd[8*b +: 8];
         end else begin
            mdout[d] = mm[d][idx];
         end
      end
      for (int n = 1; n <= lat + 1; n++) begin
         @(negedge clk);
         if (n == lat) exp_resp = (k == 0) ? 3'b100 : (k == 1) ? 3'b010 : 3'b001;
         else          exp_resp = 3'b000;
         check($sformatf("d%0d a%0h resp n%0d", d, a, n), {ack[d], err[d], rty[d]}, exp_resp);
         if (n >= lat) check($sformatf("d%0d a%0h dat_o n%0d", d, a, n), dout[d], mdout[d]);
         if (n < lat) begin
            adr  = $urandom;
            dat  = $urandom;
            we   = 1'($urandom);
            sel  = 4'($urandom);
            hold = 1'($urandom);
         end
         if (n == lat) begin
            stb[d] = 1'b0;
            cyc    = 1'b0;
         end
      end
      rd = dout[d];
   endtask

   // Write request abandoned at cycle drop_n, by dropping stb or by reset.
   task automatic abort_xfer(input int d, input logic [31:0] a, input logic [31:0] wd,
                             input int drop_n, input bit use_rst);
      @(negedge clk);
      adr = a; dat = wd; we = 1'b1; sel = 4'hF; hold = 1'b0; cyc = 1'b1; stb[d] = 1'b1;
      for (int n = 1; n <= drop_n; n++) begin
         @(negedge clk);
         check($sformatf("d%0d abort resp n%0d", d, n), {ack[d], err[d], rty[d]}, 3'b000);
         if (n == drop_n) begin
            stb[d] = 1'b0;
            cyc    = 1'b0;
            if (use_rst) rst = 1'b1;
         end
      end
      if (use_rst) begin
         @(negedge clk);
         check($sformatf("d%0d rst dat_o", d), dout[d], 32'h0);
         rst = 1'b0;
         for (int dd = 0; dd < NDUT; dd++) mdout[dd] = 32'h0;
      end
      for (int n = 0; n < wait_of(d) + 2; n++) begin
         @(negedge clk);
         check($sformatf("d%0d post-abort resp", d), {ack[d], err[d], rty[d]}, 3'b000);
      end
   endtask

   initial begin
      logic [31:0] rd;
      logic [31:0] a;
      int          d;
      int          r;

      // Reset held for two cycles with a live request on every instance.
      rst = 1'b1; adr = BASE; dat = 32'h1234_5678; we = 1'b1; sel = 4'hF;
      cyc = 1'b1; stb = '1; hold = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         for (int i = 0; i < NDUT; i++) begin
            check($sformatf("rst d%0d resp", i), {ack[i], err[i], rty[i]}, 3'b000);
            check($sformatf("rst d%0d dat_o", i), dout[i], 32'h0);
         end
      end
      rst = 1'b0; stb = '0; cyc = 1'b0;
      for (int i = 0; i < NDUT; i++) mdout[i] = 32'h0;
      @(negedge clk);
      for (int i = 0; i < NDUT; i++)
         check($sformatf("post-rst d%0d resp", i), {ack[i], err[i], rty[i]}, 3'b000);

      // Fill every word so all later reads have defined contents.
      for (int i = 0; i < NDUT; i++)
         for (int j = 0; j < DEPTH; j++)
            xfer(i, BASE + 32'(4 * j), 1'b1, $urandom, 4'hF, 1'b0, rd);

      // Full-word write/read on the two-wait-state instance.
      xfer(1, BASE + 4, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b0, rd);
      xfer(1, BASE + 4, 1'b0, 32'h0, 4'hF, 1'b0, rd);
      check("w2 read full word", rd, 32'hDEAD_BEEF);

      // Single-lane write, then an all-lanes-off write.
      xfer(1, BASE + 4, 1'b1, 32'h0000_AA00, 4'b0010, 1'b0, rd);
      xfer(1, BASE + 4, 1'b0, 32'h0, 4'hF, 1'b0, rd);
      check("w2 read lane1", rd, 32'hDEAD_AAEF);
      xfer(1, BASE + 4, 1'b1, 32'hFFFF_FFFF, 4'b0000, 1'b0, rd);
      xfer(1, BASE + 4, 1'b0, 32'h0, 4'hF, 1'b0, rd);
      check("w2 read sel0", rd, 32'hDEAD_AAEF);

      // Decode errors: just past the window and misaligned.
      xfer(1, BASE + DEPTH * SW, 1'b1, 32'h1111_1111, 4'hF, 1'b0, rd);
      xfer(1, BASE + 2, 1'b1, 32'h2222_2222, 4'hF, 1'b0, rd);
      check("err keeps dat_o", rd, 32'hDEAD_AAEF);
      xfer(1, BASE + 4, 1'b0, 32'h0, 4'hF, 1'b0, rd);
      check("err leaves ram", rd, 32'hDEAD_AAEF);

      // Retry while held, then the same write accepted.
      xfer(1, BASE + 8, 1'b1, 32'hCAFE_F00D, 4'hF, 1'b1, rd);
      xfer(1, BASE + 8, 1'b0, 32'h0, 4'hF, 1'b0, rd);
      check("rty no write", rd, mm[1][2]);
      xfer(1, BASE + 8, 1'b1, 32'hCAFE_F00D, 4'hF, 1'b0, rd);
      xfer(1, BASE + 8, 1'b0, 32'h0, 4'hF, 1'b0, rd);
      check("write after rty", rd, 32'hCAFE_F00D);

      // Abort in the second wait cycle, then a normal read (latency 4).
      abort_xfer(2, BASE + 12, 32'hBAD0_BAD0, 2, 1'b0);
      xfer(2, BASE + 12, 1'b0, 32'h0, 4'hF, 1'b0, rd);
      check("abort no write", rd, mm[2][3]);

      // Reset during a wait cycle cancels the write.
      abort_xfer(2, BASE + 16, 32'h0BAD_C0DE, 1, 1'b1);
      xfer(2, BASE + 16, 1'b0, 32'h0, 4'hF, 1'b0, rd);
      check("rst abort no write", rd, mm[2][4]);

      // Randomised traffic across all instances.
      for (int it = 0; it < 150; it++) begin
         d = int'($urandom % NDUT);
         r = int'($urandom % 10);
         if (r < 7)       a = BASE + 32'(4 * ($urandom % DEPTH));
         else if (r == 7) a = BASE + 32'(4 * ($urandom % DEPTH)) + 32'(1 + $urandom % 3);
         else if (r == 8) a = BASE + 32'(DEPTH * SW) + 32'(4 * ($urandom % 4));
         else             a = BASE - 32'(4 * (1 + $urandom % 4));
         xfer(d, a, 1'($urandom), $urandom, 4'($urandom), ($urandom % 6) == 0, rd);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
